// File: rtl/call_debit_sched_if.sv
// Line/billing bus of the prepaid call debit scheduler.
// The master side drives the line state; the slave side reports billing.
interface call_debit_sched_if;
  logic [3:0]  calling;
  logic [7:0]  ltype;
  logic [10:0] balance;
  logic [3:0]  grant;
  logic        write;
  logic [3:0]  warn;
  logic [3:0]  cut;

  modport master (output calling, ltype, input balance, grant, write, warn, cut);
  modport slave  (input calling, ltype, output balance, grant, write, warn, cut);
endinterface

// File: rtl/call_debit_sched.sv
// Four-line prepaid call billing: per-line minute timers, round-robin debit of a
// shared BCD balance, low-balance warning and forced disconnect.
module call_debit_sched #(
  parameter logic [10:0] INIT_BAL = 11'h500,
  parameter int          TICKS    = 60
) (
  input  logic              clk,
  input  logic              rst,
  call_debit_sched_if.slave bus
);
  localparam int SW = $clog2(TICKS);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_UPDATE} state_t;

  function automatic logic [3:0] rate_of(input logic [1:0] code);
    case (code)
      2'b01:   rate_of = 4'd3;
      2'b10:   rate_of = 4'd6;
      default: rate_of = 4'd0;
    endcase
  endfunction

  // Caller guarantees b >= r, so the hundreds digit never underflows.
  function automatic logic [10:0] bcd_sub(input logic [10:0] b, input logic [3:0] r);
    logic [3:0] u, t;
    logic [2:0] h;
    logic       bu, bt;
    if (b[3:0] >= r) begin
      u  = b[3:0] - r;
      bu = 1'b0;
    end else begin
      u  = b[3:0] + 4'd10 - r;
      bu = 1'b1;
    end
    if (b[7:4] >= {3'b000, bu}) begin
      t  = b[7:4] - {3'b000, bu};
      bt = 1'b0;
    end else begin
      t  = 4'd9;
      bt = 1'b1;
    end
    h = b[10:8] - {2'b00, bt};
    bcd_sub = {h, t, u};
  endfunction

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d, rr_q, rr_d;
  logic [3:0]        rate_q, rate_d;
  logic [10:0]       bal_q, bal_d;
  logic [3:0]        grant_q, grant_d;
  logic              write_q, write_d;
  logic [3:0]        pend_q, pend_d, warn_q, warn_d, cut_q, cut_d;
  logic [3:0][SW-1:0] sec_q, sec_d;
  logic [3:0][3:0]   wcnt_q, wcnt_d;

  logic [3:0] billable_s, req_s, tick_s, svc_clr_s, warn_set_s, warn_clr_s;
  logic       found_s;
  logic [1:0] j_s;

  // Scheduler FSM and per-line timer, pending, warning and disconnect logic.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rate_d     = rate_q;
    rr_d       = rr_q;
    bal_d      = bal_q;
    grant_d    = 4'b0000;
    write_d    = 1'b0;
    svc_clr_s  = 4'b0000;
    warn_set_s = 4'b0000;
    warn_clr_s = 4'b0000;
    found_s    = 1'b0;
    j_s        = 2'd0;
    for (int i = 0; i < 4; i++) begin
      billable_s[i] = (rate_of(bus.ltype[2*i +: 2]) != 4'd0);
    end
    req_s = pend_q & billable_s & ~cut_q;

    case (state_q)
      S_IDLE: begin
        for (int k = 0; k < 4; k++) begin
          j_s = rr_q + 2'(k);
          if (!found_s && req_s[j_s]) begin
            found_s      = 1'b1;
            idx_d        = j_s;
            rate_d       = rate_of(bus.ltype[{j_s, 1'b0} +: 2]);
            rr_d         = j_s + 2'd1;
            grant_d[j_s] = 1'b1;
            state_d      = S_GRANT;
          end else begin
            found_s = found_s;
          end
        end
      end
      S_GRANT: begin
        if (bal_q >= {7'd0, rate_q}) begin
          bal_d   = bcd_sub(bal_q, rate_q);
          write_d = 1'b1;
          state_d = S_UPDATE;
        end else begin
          warn_set_s[idx_q] = 1'b1;
          svc_clr_s[idx_q]  = 1'b1;
          state_d           = S_IDLE;
        end
      end
      S_UPDATE: begin
        svc_clr_s[idx_q]  = 1'b1;
        warn_clr_s[idx_q] = 1'b1;
        state_d           = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    for (int i = 0; i < 4; i++) begin
      tick_s[i] = bus.calling[i] && !cut_q[i] && (sec_q[i] == SW'(TICKS - 1));
      if (!bus.calling[i] || cut_q[i] || tick_s[i]) begin
        sec_d[i] = '0;
      end else begin
        sec_d[i] = sec_q[i] + SW'(1);
      end
      // A tick in the same cycle as a service clear keeps the new request.
      pend_d[i] = bus.calling[i] &&
                  (tick_s[i] || (pend_q[i] && billable_s[i] && !svc_clr_s[i] && !cut_q[i]));
      warn_d[i] = bus.calling[i] && (warn_q[i] || warn_set_s[i]) && !warn_clr_s[i];
      cut_d[i]  = cut_q[i];
      wcnt_d[i] = wcnt_q[i];
      if (!bus.calling[i]) begin
        cut_d[i]  = 1'b0;
        wcnt_d[i] = 4'd0;
      end else if (warn_q[i] && !cut_q[i]) begin
        if (wcnt_q[i] == 4'd14) begin
          cut_d[i]  = 1'b1;
          wcnt_d[i] = 4'd0;
        end else begin
          wcnt_d[i] = wcnt_q[i] + 4'd1;
        end
      end else if (!warn_q[i]) begin
        wcnt_d[i] = 4'd0;
      end else begin
        wcnt_d[i] = wcnt_q[i];
      end
    end
  end

  // State registers; reset abandons any in-flight debit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      rr_q    <= 2'd0;
      rate_q  <= 4'd0;
      bal_q   <= INIT_BAL;
      grant_q <= 4'b0000;
      write_q <= 1'b0;
      pend_q  <= 4'b0000;
      warn_q  <= 4'b0000;
      cut_q   <= 4'b0000;
      sec_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      rate_q  <= rate_d;
      bal_q   <= bal_d;
      grant_q <= grant_d;
      write_q <= write_d;
      pend_q  <= pend_d;
      warn_q  <= warn_d;
      cut_q   <= cut_d;
      sec_q   <= sec_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign bus.balance = bal_q;
  assign bus.grant   = grant_q;
  assign bus.write   = write_q;
  assign bus.warn    = warn_q;
  assign bus.cut     = cut_q;
endmodule

// File: tb/tb_call_debit_sched.sv
// Bench for call_debit_sched: a decimal-balance reference model checked every
// cycle on the default instance, plus directed BCD borrow and warn/cut cases.
module tb_call_debit_sched;
  localparam int TA = 60;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   chk_en   = 1'b0;

  call_debit_sched_if ifa ();
  call_debit_sched_if ifb ();
  call_debit_sched_if ifc ();

  call_debit_sched dut_a (.clk(clk), .rst(rst), .bus(ifa));
  call_debit_sched #(.INIT_BAL(11'h100), .TICKS(12)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  call_debit_sched #(.INIT_BAL(11'h010), .TICKS(12)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int cost(input logic [1:0] c);
    return (c == 2'b01) ? 3 : ((c == 2'b10) ? 6 : 0);
  endfunction

  function automatic logic [31:0] to_bcd(input int v);
    return 32'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
  endfunction

  // Reference model: balance is a plain decimal integer; service is a 3-phase job.
  int        m_sec[4], m_wc[4];
  bit [3:0]  m_pend, m_warn, m_cut, m_grant;
  bit        m_write;
  int        m_bal, m_rr, m_phase, m_cur, m_rate;

  always @(posedge clk or posedge rst) begin : model
    int       n_sec[4], n_wc[4];
    bit [3:0] n_pend, n_warn, n_cut, n_grant, clr, wset, wclr;
    bit       n_write, tick, picked;
    int       n_bal, n_rr, n_phase, n_cur, n_rate, j, nw;
    if (rst) begin
      m_sec <= '{0, 0, 0, 0};
      m_wc  <= '{0, 0, 0, 0};
      m_pend <= 4'b0; m_warn <= 4'b0; m_cut <= 4'b0; m_grant <= 4'b0;
      m_write <= 1'b0;
      m_bal <= 500; m_rr <= 0; m_phase <= 0; m_cur <= 0; m_rate <= 0;
    end else begin
      n_bal = m_bal; n_rr = m_rr; n_phase = m_phase; n_cur = m_cur; n_rate = m_rate;
      n_grant = 4'b0; n_write = 1'b0; clr = 4'b0; wset = 4'b0; wclr = 4'b0; picked = 1'b0;
      if (m_phase == 0) begin
        for (int k = 0; k < 4; k++) begin
          j = (m_rr + k) % 4;
          if (!picked && m_pend[j] && !m_cut[j] && cost(ifa.ltype[2*j +: 2]) > 0) begin
            picked = 1'b1; n_cur = j; n_rate = cost(ifa.ltype[2*j +: 2]);
            n_rr = (j + 1) % 4; n_grant[j] = 1'b1; n_phase = 1;
          end
        end
      end else if (m_phase == 1) begin
        if (m_bal >= m_rate) begin
          n_bal = m_bal - m_rate; n_write = 1'b1; n_phase = 2;
        end else begin
          wset[m_cur] = 1'b1; clr[m_cur] = 1'b1; n_phase = 0;
        end
      end else begin
        clr[m_cur] = 1'b1; wclr[m_cur] = 1'b1; n_phase = 0;
      end
      for (int i = 0; i < 4; i++) begin
        tick = ifa.calling[i] && !m_cut[i] && (m_sec[i] == TA - 1);
        n_sec[i] = (!ifa.calling[i] || m_cut[i] || tick) ? 0 : m_sec[i] + 1;
        n_pend[i] = m_pend[i] && (cost(ifa.ltype[2*i +: 2]) != 0) && !clr[i] && !m_cut[i];
        if (tick) n_pend[i] = 1'b1;
        if (!ifa.calling[i]) n_pend[i] = 1'b0;
        n_warn[i] = (m_warn[i] || wset[i]) && !wclr[i] && ifa.calling[i];
        n_cut[i] = m_cut[i];
        n_wc[i]  = m_wc[i];
        if (!ifa.calling[i]) begin
          n_cut[i] = 1'b0; n_wc[i] = 0;
        end else if (m_warn[i] && !m_cut[i]) begin
          nw = m_wc[i] + 1;
          if (nw == 15) begin n_cut[i] = 1'b1; n_wc[i] = 0; end
          else n_wc[i] = nw;
        end else if (!m_warn[i]) begin
          n_wc[i] = 0;
        end
      end
      m_sec <= n_sec; m_wc <= n_wc; m_pend <= n_pend; m_warn <= n_warn; m_cut <= n_cut;
      m_grant <= n_grant; m_write <= n_write;
      m_bal <= n_bal; m_rr <= n_rr; m_phase <= n_phase; m_cur <= n_cur; m_rate <= n_rate;
    end
  end

  // Per-cycle comparison of the default instance against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("a_balance", 32'(ifa.balance), to_bcd(m_bal));
      check("a_grant",   32'(ifa.grant),   32'(m_grant));
      check("a_write",   32'(ifa.write),   32'(m_write));
      check("a_warn",    32'(ifa.warn),    32'(m_warn));
      check("a_cut",     32'(ifa.cut),     32'(m_cut));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : stim
    bit found;
    bit c_wrote;
    logic [3:0] exp_g;
    rst = 1'b1;
    ifa.calling = 4'b0; ifa.ltype = 8'h00;
    ifb.calling = 4'b0; ifb.ltype = 8'h00;
    ifc.calling = 4'b0; ifc.ltype = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("reset_balance", 32'(ifa.balance), 32'h500);
    check("reset_grant", 32'(ifa.grant), 32'h0);
    check("reset_warn_cut", 32'({ifa.warn, ifa.cut, 3'b000, ifa.write}), 32'h0);
    rst = 1'b0;

    // Single line, rate 3.
    ifa.calling = 4'b0001; ifa.ltype = 8'h01;
    for (int cyc = 1; cyc <= 62; cyc++) begin
      @(posedge clk); @(negedge clk);
      if (cyc == 60) check("single_no_grant_60", 32'(ifa.grant), 32'h0);
      if (cyc == 61) check("single_grant_61", 32'(ifa.grant), 32'h1);
      if (cyc == 62) begin
        check("single_write_62", 32'(ifa.write), 32'h1);
        check("single_bal_497", 32'(ifa.balance), 32'h497);
        check("model_bal_497", 32'(m_bal), 32'd497);
      end
    end

    // All four lines, rate 6, round robin.
    do_reset();
    ifa.calling = 4'b1111; ifa.ltype = 8'b10101010;
    for (int cyc = 1; cyc <= 71; cyc++) begin
      @(posedge clk); @(negedge clk);
      exp_g = (cyc == 61) ? 4'b0001 : (cyc == 64) ? 4'b0010 :
              (cyc == 67) ? 4'b0100 : (cyc == 70) ? 4'b1000 : 4'b0000;
      if (cyc >= 59) check("rr_grant", 32'(ifa.grant), 32'(exp_g));
    end
    check("rr_bal_476", 32'(ifa.balance), 32'h476);
    check("model_bal_476", 32'(m_bal), 32'd476);

    // Reset during the update cycle of the next minute's first debit.
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (ifa.grant != 4'b0) found = 1'b1;
    end
    check("abort_grant_seen", 32'(found), 32'h1);
    @(negedge clk);
    check("abort_in_update", 32'(ifa.write), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("abort_bal", 32'(ifa.balance), 32'h500);
    check("abort_outs", 32'({ifa.grant, ifa.warn, ifa.cut, 3'b000, ifa.write}), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Randomised traffic drains the balance through warnings and disconnects.
    ifa.calling = 4'b0;
    for (int i = 0; i < 4; i++) ifa.ltype[2*i +: 2] = 2'($urandom_range(0, 3));
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (ifa.calling[i]) begin
          if ($urandom_range(0, 119) == 0) ifa.calling[i] = 1'b0;
        end else begin
          if ($urandom_range(0, 19) == 0) ifa.calling[i] = 1'b1;
        end
        if ($urandom_range(0, 299) == 0) begin
          case ($urandom_range(0, 3))
            0: ifa.ltype[2*i +: 2] = 2'b01;
            1: ifa.ltype[2*i +: 2] = 2'b10;
            2: ifa.ltype[2*i +: 2] = 2'b10;
            default: ifa.ltype[2*i +: 2] = 2'($urandom_range(0, 3));
          endcase
        end
      end
    end
    ifa.calling = 4'b0;

    // BCD borrow chains, then warning and disconnect on an exhausted balance.
    do_reset();
    ifb.calling = 4'b0001; ifb.ltype = 8'h01;
    ifc.calling = 4'b0001; ifc.ltype = 8'h02;
    c_wrote = 1'b0;
    for (int cyc = 1; cyc <= 42; cyc++) begin
      @(posedge clk); @(negedge clk);
      if (cyc == 13) check("b_grant_13", 32'(ifb.grant), 32'h1);
      if (cyc == 14) begin
        check("b_bal_097", 32'(ifb.balance), 32'h097);
        check("c_bal_004", 32'(ifc.balance), 32'h004);
        check("c_write_14", 32'(ifc.write), 32'h1);
      end
      if (cyc >= 15 && ifc.write) c_wrote = 1'b1;
      if (cyc == 25) check("c_warn_pre", 32'(ifc.warn), 32'h0);
      if (cyc == 26) check("c_warn_26", 32'(ifc.warn), 32'h1);
      if (cyc == 40) check("c_cut_40", 32'(ifc.cut), 32'h0);
      if (cyc == 41) begin
        check("c_cut_41", 32'(ifc.cut), 32'h1);
        ifc.calling = 4'b0000;
      end
      if (cyc == 42) check("c_hangup_clears", 32'({ifc.warn, ifc.cut}), 32'h0);
    end
    check("c_no_write", 32'(c_wrote), 32'h0);
    check("c_bal_hold", 32'(ifc.balance), 32'h004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/call_debit_sched.md
CALL_DEBIT_SCHED -- requirements
Module: call_debit_sched

Interface
REQ-001 SHALL have parameter INIT_BAL, default 11'h500, meaning BCD reset balance {hundreds[10:8], tens[7:4], units[3:0]}.
REQ-002 SHALL have parameter TICKS, default 60, meaning clk cycles per billed minute (clk is 1 Hz).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on posedge.
REQ-004 SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-005 SHALL have port calling, input, 4, meaning line i off-hook when calling[i]=1.
REQ-006 SHALL have port ltype, input, 8, meaning rate class of line i on ltype[2i+1:2i]: 2'b01 costs 3, 2'b10 costs 6, other codes are free.
REQ-007 SHALL have port balance, output, 11, meaning shared BCD prepaid balance.
REQ-008 SHALL have port grant, output, 4, meaning one-hot pulse marking the line being serviced.
REQ-009 SHALL have port write, output, 1, meaning one-cycle pulse when balance is updated.
REQ-010 SHALL have ports warn and cut, output, 4 each, meaning per-line low-balance warning and forced disconnect.

Function
REQ-011 SHALL keep one seconds counter per line: 0 when calling[i]=0 or cut[i]=1, else +1 per cycle; at TICKS-1 it wraps to 0 and sets pending[i].
REQ-012 SHALL clear pending[i] instead of servicing it when ltype of line i is free; no grant, no write.
REQ-013 SHALL run FSM IDLE -> GRANT -> UPDATE -> IDLE; GRANT -> IDLE on insufficient balance.
REQ-014 In IDLE with any billable pending bit, SHALL pick the first pending line at or after rr_ptr, cyclic 0..3, latch index and rate, and go to GRANT; rr_ptr <= index+1 mod 4.
REQ-015 In GRANT, grant[index] SHALL be 1 for exactly that cycle; if balance >= rate, go to UPDATE; else set warn[index], clear pending[index], go to IDLE.
REQ-016 In UPDATE, SHALL load balance with balance minus rate in BCD (units borrow from tens, tens from hundreds), pulse write, clear pending[index], clear warn[index].
REQ-017 Balance SHALL never go below 000; a debit only executes when balance >= rate.
REQ-018 Service takes 3 cycles; with TICKS >= 12 at most one pending request per line exists and no minute is lost.
REQ-019 When warn[i]=1 and calling[i]=1, a 4-bit per-line counter SHALL increment each cycle; when it equals 15, cut[i] <= 1 and the counter clears.
REQ-020 cut[i] SHALL stay 1 until calling[i]=0; while cut, line i raises no requests.
REQ-021 When calling[i] falls, SHALL clear seconds counter, pending[i], warn[i], cut[i] and warn counter of line i on the next edge.
REQ-022 If calling[index] falls while in GRANT or UPDATE, the in-flight debit SHALL still complete.
REQ-023 A new tick on a line during its own service SHALL set pending after the clear: set wins over clear.

Reset
REQ-024 On rst=1, without waiting for clk: balance=INIT_BAL, grant=0, write=0, warn=0, cut=0, all counters and pending=0, rr_ptr=0, FSM=IDLE.
REQ-025 Reset asserted mid-service SHALL abort the debit; balance returns to INIT_BAL.

Verification
REQ-026 Line 0 calling with ltype 01 for 60 cycles -> grant=0001 at cycle 61, write pulse at 62, balance 11'h497.
REQ-027 Lines 0-3 all start together with ltype 10 -> grants 0001, 0010, 0100, 1000 in order, 3 cycles apart; final balance 11'h476.
REQ-028 Balance 11'h100 minus 3 -> 11'h097; balance 11'h010 minus 6 -> 11'h004 (borrow chains checked).
REQ-029 Balance 11'h005 with ltype 10 -> warn[i]=1, no write; cut[i]=1 after 15 more calling cycles; calling low clears both next cycle.
REQ-030 rst pulsed during UPDATE -> balance=11'h500 and all outputs 0 immediately, with no write pulse.
